// File: rtl/vx_lsu_serializer_pkg.sv
// Shared constants and state encoding for the memory-stage load/store serializer.
package vx_lsu_serializer_pkg;

  localparam logic [2:0]  NO_MEM_READ  = 3'h7;
  localparam logic [2:0]  NO_MEM_WRITE = 3'h7;
  localparam logic [31:0] RESULT_FILL  = 32'hBABEBABE;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/vx_lane_pick.sv
// Lowest-set-bit priority encoder: picks the next lane to serve from a remaining-lane mask.
module vx_lane_pick #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned LANE_W      = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] mask_i,
  output logic [LANE_W-1:0]      lane_o,
  output logic                   any_o
);

  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    lane_o = '0;
    any_o  = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lane_o = LANE_W'(i);
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_lsu_serializer.sv
// Serializes a per-lane memory op into single cache requests in ascending lane order,
// gathering load data and stalling the pipeline until every active lane completes.
module vx_lsu_serializer
  import vx_lsu_serializer_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_WARPS   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_THREADS-1:0]        in_valid,
  input  logic [NUM_THREADS*32-1:0]     in_address,
  input  logic [NUM_THREADS*32-1:0]     in_data,
  input  logic [2:0]                    in_mem_read,
  input  logic [2:0]                    in_mem_write,
  input  logic [$clog2(NUM_WARPS)-1:0]  in_warp_num,
  output logic                          out_delay,
  output logic [NUM_THREADS*32-1:0]     out_mem_result,
  output logic [$clog2(NUM_WARPS)-1:0]  out_warp_num,
  output logic                          out_done,
  output logic                          dc_req_valid,
  input  logic                          dc_req_ready,
  output logic [31:0]                   dc_req_addr,
  output logic [31:0]                   dc_req_data,
  output logic [2:0]                    dc_req_mem_read,
  output logic [2:0]                    dc_req_mem_write,
  input  logic                          dc_rsp_valid,
  input  logic [31:0]                   dc_rsp_data
);

  localparam int unsigned LaneW = $clog2(NUM_THREADS);
  localparam int unsigned WarpW = $clog2(NUM_WARPS);

  lsu_state_e             state_q, state_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d, mask_clr;
  logic [31:0]            addr_q [NUM_THREADS];
  logic [31:0]            addr_d [NUM_THREADS];
  logic [31:0]            data_q [NUM_THREADS];
  logic [31:0]            data_d [NUM_THREADS];
  logic [31:0]            result_q [NUM_THREADS];
  logic [31:0]            result_d [NUM_THREADS];
  logic [2:0]             rd_q, rd_d, wr_q, wr_d;
  logic [WarpW-1:0]       warp_q, warp_d;
  logic [LaneW-1:0]       lane_q, lane_d;
  logic [LaneW-1:0]       pick_lane;
  logic                   pick_any;
  logic                   mem_op, is_load;

  vx_lane_pick #(
    .NUM_THREADS (NUM_THREADS),
    .LANE_W      (LaneW)
  ) u_lane_pick (
    .mask_i (mask_q),
    .lane_o (pick_lane),
    .any_o  (pick_any)
  );

  assign mem_op  = ((in_mem_read != NO_MEM_READ) || (in_mem_write != NO_MEM_WRITE)) && |in_valid;
  assign is_load = (rd_q != NO_MEM_READ);

  assign dc_req_addr      = addr_q[pick_lane];
  assign dc_req_data      = data_q[pick_lane];
  assign dc_req_mem_read  = rd_q;
  assign dc_req_mem_write = wr_q;
  assign out_warp_num     = warp_q;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      out_mem_result[i*32 +: 32] = result_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    data_d       = data_q;
    result_d     = result_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    warp_d       = warp_q;
    lane_d       = lane_q;
    out_delay    = 1'b0;
    out_done     = 1'b0;
    dc_req_valid = 1'b0;
    mask_clr     = mask_q;
    mask_clr[pick_lane] = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_delay = mem_op;
        if (mem_op) begin
          mask_d = in_valid;
          for (int i = 0; i < NUM_THREADS; i++) begin
            addr_d[i]   = in_address[i*32 +: 32];
            data_d[i]   = in_data[i*32 +: 32];
            result_d[i] = RESULT_FILL;
          end
          rd_d    = in_mem_read;
          // A load that also carries a store type is treated as a pure load.
          wr_d    = (in_mem_read != NO_MEM_READ) ? NO_MEM_WRITE : in_mem_write;
          warp_d  = in_warp_num;
          state_d = StReq;
        end
      end
      StReq: begin
        out_delay    = 1'b1;
        dc_req_valid = pick_any;
        if (pick_any && dc_req_ready) begin
          mask_d = mask_clr;
          lane_d = pick_lane;
          if (is_load)        state_d = StWait;
          else if (|mask_clr) state_d = StReq;
          else                state_d = StDone;
        end
      end
      StWait: begin
        out_delay = 1'b1;
        if (dc_rsp_valid) begin
          result_d[lane_q] = dc_rsp_data;
          state_d          = (|mask_q) ? StReq : StDone;
        end
      end
      StDone: begin
        out_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      rd_q    <= NO_MEM_READ;
      wr_q    <= NO_MEM_WRITE;
      warp_q  <= '0;
      lane_q  <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        result_q[i] <= RESULT_FILL;
      end
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      warp_q   <= warp_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

endmodule
